// File: rtl/conv_pkg.sv
// Shared definitions for the convolution controller: parameter defaults,
// field widths and FSM state encodings.
package conv_pkg;

  localparam int unsigned K_DEF          = 16;
  localparam int unsigned N_DEF          = 4;
  localparam int unsigned BUF_WORDS_DEF  = 4;
  localparam int unsigned NUM_WIN_DEF    = 64;
  localparam int unsigned FILT_BASE_DEF  = 0;
  localparam int unsigned IFM_BASE_DEF   = 64;
  localparam int unsigned WIN_STRIDE_DEF = 1;

  localparam int unsigned ST_W   = 4;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned ADDR_W = 10;

  localparam logic [ST_W-1:0] S_IDLE    = 4'd0;
  localparam logic [ST_W-1:0] S_LD_FILT = 4'd1;
  localparam logic [ST_W-1:0] S_LD_BUF  = 4'd2;
  localparam logic [ST_W-1:0] S_FILL    = 4'd3;
  localparam logic [ST_W-1:0] S_MAC     = 4'd4;
  localparam logic [ST_W-1:0] S_ACC     = 4'd5;
  localparam logic [ST_W-1:0] S_WR      = 4'd6;
  localparam logic [ST_W-1:0] S_NXT     = 4'd7;
  localparam logic [ST_W-1:0] S_DONE    = 4'd8;

endpackage

// File: rtl/conv_addr_gen.sv
// Address decode for the convolution controller: memory, main-buffer and
// output-feature-map addresses derived from the current state and counters.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int unsigned K          = K_DEF,
  parameter int unsigned FILT_BASE  = FILT_BASE_DEF,
  parameter int unsigned IFM_BASE   = IFM_BASE_DEF,
  parameter int unsigned WIN_STRIDE = WIN_STRIDE_DEF,
  parameter int unsigned PE_W       = 2
) (
  input  logic [ST_W-1:0]   state_i,
  input  logic [PE_W-1:0]   pe_i,
  input  logic [CNT_W-1:0]  fc_i,
  input  logic [CNT_W-1:0]  ba_i,
  input  logic [ADDR_W-1:0] win_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [CNT_W-1:0]  buff_addr_o,
  output logic [ADDR_W-1:0] ofm_addr_o
);

  // Sums are formed at 32 bits and truncated, giving silent modulo-1024 wrap.
  always_comb begin
    mem_addr_o  = '0;
    buff_addr_o = '0;
    ofm_addr_o  = '0;
    case (state_i)
      S_LD_FILT: mem_addr_o = ADDR_W'(FILT_BASE + 32'(pe_i) * K + 32'(fc_i));
      S_LD_BUF: begin
        mem_addr_o  = ADDR_W'(IFM_BASE + 32'(win_i) * WIN_STRIDE + 32'(ba_i));
        buff_addr_o = ba_i;
      end
      S_WR:      ofm_addr_o = win_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/conv_controller.sv
// Sequencer for a 1-D convolution datapath: loads filters, then for every
// output window loads the buffer, fills the window, runs the MAC and writes.
module conv_controller
  import conv_pkg::*;
#(
  parameter int unsigned N          = N_DEF,
  parameter int unsigned K          = K_DEF,
  parameter int unsigned BUF_WORDS  = BUF_WORDS_DEF,
  parameter int unsigned NUM_WIN    = NUM_WIN_DEF,
  parameter int unsigned FILT_BASE  = FILT_BASE_DEF,
  parameter int unsigned IFM_BASE   = IFM_BASE_DEF,
  parameter int unsigned WIN_STRIDE = WIN_STRIDE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              wEnBuff,
  output logic              w_r_EnMem,
  output logic              writeEnwindow,
  output logic              readEnmac,
  output logic              addEn,
  output logic              winRst,
  output logic              wrofm,
  output logic [CNT_W-1:0]  filterCount,
  output logic [CNT_W-1:0]  macCount,
  output logic [ADDR_W-1:0] memAddress,
  output logic [CNT_W-1:0]  buffAddress,
  output logic [ADDR_W-1:0] ofmaddr,
  output logic [N-1:0]      wEnFilter
);

  localparam int unsigned PE_W = (N > 1) ? $clog2(N) : 1;

  logic [ST_W-1:0]   state_q, state_d;
  logic [PE_W-1:0]   pe_q, pe_d;
  logic [CNT_W-1:0]  fc_q, fc_d;
  logic [CNT_W-1:0]  ba_q, ba_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] win_q, win_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pe_q    <= '0;
      fc_q    <= '0;
      ba_q    <= '0;
      cnt_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      pe_q    <= pe_d;
      fc_q    <= fc_d;
      ba_q    <= ba_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
    end
  end

  // cnt_q is shared by FILL and MAC; each phase restarts it from zero.
  always_comb begin
    state_d = state_q;
    pe_d    = pe_q;
    fc_d    = fc_q;
    ba_d    = ba_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LD_FILT;
          pe_d    = '0;
          fc_d    = '0;
          ba_d    = '0;
          cnt_d   = '0;
          win_d   = '0;
        end
      end
      S_LD_FILT: begin
        if (fc_q == CNT_W'(K - 1)) begin
          fc_d = '0;
          if (pe_q == PE_W'(N - 1)) begin
            state_d = S_LD_BUF;
            ba_d    = '0;
          end else begin
            pe_d = pe_q + PE_W'(1);
          end
        end else begin
          fc_d = fc_q + CNT_W'(1);
        end
      end
      S_LD_BUF: begin
        if (ba_q == CNT_W'(BUF_WORDS - 1)) begin
          state_d = S_FILL;
          cnt_d   = '0;
        end else begin
          ba_d = ba_q + CNT_W'(1);
        end
      end
      S_FILL, S_MAC: begin
        if (cnt_q == CNT_W'(K - 1)) begin
          state_d = (state_q == S_FILL) ? S_MAC : S_ACC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ACC:  state_d = S_WR;
      S_WR:   state_d = (win_q == ADDR_W'(NUM_WIN - 1)) ? S_DONE : S_NXT;
      S_NXT: begin
        state_d = S_LD_BUF;
        win_d   = win_q + ADDR_W'(1);
        ba_d    = '0;
      end
      S_DONE: begin
        state_d = S_IDLE;
        pe_d    = '0;
        fc_d    = '0;
        ba_d    = '0;
        cnt_d   = '0;
        win_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore strobe decode; at most one strobe per state by construction.
  always_comb begin
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    w_r_EnMem     = 1'b0;
    wEnBuff       = (state_q == S_LD_BUF);
    writeEnwindow = (state_q == S_FILL);
    readEnmac     = (state_q == S_MAC);
    addEn         = (state_q == S_ACC);
    wrofm         = (state_q == S_WR);
    winRst        = (state_q == S_NXT);
    filterCount   = (state_q == S_LD_FILT) ? fc_q : '0;
    macCount      = (state_q == S_MAC) ? cnt_q : '0;
    wEnFilter     = (state_q == S_LD_FILT) ? (N'(1) << pe_q) : '0;
  end

  conv_addr_gen #(
    .K          (K),
    .FILT_BASE  (FILT_BASE),
    .IFM_BASE   (IFM_BASE),
    .WIN_STRIDE (WIN_STRIDE),
    .PE_W       (PE_W)
  ) u_addr_gen (
    .state_i     (state_q),
    .pe_i        (pe_q),
    .fc_i        (fc_q),
    .ba_i        (ba_q),
    .win_i       (win_q),
    .mem_addr_o  (memAddress),
    .buff_addr_o (buffAddress),
    .ofm_addr_o  (ofmaddr)
  );

endmodule

// File: tb/tb_conv_controller.sv
// Scoreboard bench for conv_controller: a two-window instance, a full default
// instance and a wrapping single-PE instance.
module tb_conv_controller;
  import conv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_a, start_b, start_c;

  logic busy_a, done_a, wenbuff_a, wrmem_a, wewin_a, remac_a, adden_a, winrst_a, wrofm_a;
  logic [5:0] fc_a, mc_a, ba_a;
  logic [9:0] mem_a, ofm_a;
  logic [3:0] wef_a;

  logic busy_b, done_b, wenbuff_b, wrmem_b, wewin_b, remac_b, adden_b, winrst_b, wrofm_b;
  logic [5:0] fc_b, mc_b, ba_b;
  logic [9:0] mem_b, ofm_b;
  logic [3:0] wef_b;

  logic busy_c, done_c, wenbuff_c, wrmem_c, wewin_c, remac_c, adden_c, winrst_c, wrofm_c;
  logic [5:0] fc_c, mc_c, ba_c;
  logic [9:0] mem_c, ofm_c;
  logic [0:0] wef_c;

  conv_controller #(.NUM_WIN(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .wEnBuff(wenbuff_a), .w_r_EnMem(wrmem_a), .writeEnwindow(wewin_a),
    .readEnmac(remac_a), .addEn(adden_a), .winRst(winrst_a), .wrofm(wrofm_a),
    .filterCount(fc_a), .macCount(mc_a), .memAddress(mem_a),
    .buffAddress(ba_a), .ofmaddr(ofm_a), .wEnFilter(wef_a));

  conv_controller dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .wEnBuff(wenbuff_b), .w_r_EnMem(wrmem_b), .writeEnwindow(wewin_b),
    .readEnmac(remac_b), .addEn(adden_b), .winRst(winrst_b), .wrofm(wrofm_b),
    .filterCount(fc_b), .macCount(mc_b), .memAddress(mem_b),
    .buffAddress(ba_b), .ofmaddr(ofm_b), .wEnFilter(wef_b));

  conv_controller #(.N(1), .K(8), .NUM_WIN(1), .FILT_BASE(1020)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c),
    .wEnBuff(wenbuff_c), .w_r_EnMem(wrmem_c), .writeEnwindow(wewin_c),
    .readEnmac(remac_c), .addEn(adden_c), .winRst(winrst_c), .wrofm(wrofm_c),
    .filterCount(fc_c), .macCount(mc_c), .memAddress(mem_c),
    .buffAddress(ba_c), .ofmaddr(ofm_c), .wEnFilter(wef_c));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] kind, input logic [11:0] hi,
                                      input logic [15:0] lo);
    return {kind, hi, lo};
  endfunction

  logic [31:0] q_a[$];
  logic [31:0] q_c[$];
  int winrst_cnt_a, done_cnt_a, exp_mc_a;
  int mac_cnt_b, filt_b, win_b, buf_b;

  task automatic sb_pop_a(input string tag, input logic [31:0] got);
    logic [31:0] exp;
    if (q_a.size() == 0) check({tag, "_unexpected"}, got, 32'hDEAD_BEEF);
    else begin
      exp = q_a.pop_front();
      check(tag, got, exp);
    end
  endtask

  task automatic push_run_a();
    for (int pe = 0; pe < 4; pe++)
      for (int fc = 0; fc < 16; fc++)
        q_a.push_back(enc(4'd1, {2'b0, 4'(1 << pe), 6'(fc)}, 16'(pe * 16 + fc)));
    for (int w = 0; w < 2; w++) begin
      for (int b = 0; b < 4; b++)
        q_a.push_back(enc(4'd2, 12'(b), 16'(64 + w + b)));
      q_a.push_back(enc(4'd3, 12'd0, 16'(w)));
    end
    q_a.push_back(enc(4'd4, 12'd0, 16'd0));
  endtask

  // Instance A: scoreboard of load/write/done events plus per-cycle invariants.
  always @(negedge clk) begin
    if (rst) exp_mc_a = 0;
    else begin
      check("onehot_a", 32'($countones({wenbuff_a, wewin_a, remac_a, adden_a,
                                         wrofm_a, winrst_a, |wef_a}) > 1), 32'd0);
      check("rdonly_a", 32'(wrmem_a), 32'd0);
      if (|wef_a)    sb_pop_a("filt_a", enc(4'd1, {2'b0, wef_a, fc_a}, {6'b0, mem_a}));
      if (wenbuff_a) sb_pop_a("buf_a", enc(4'd2, {6'b0, ba_a}, {6'b0, mem_a}));
      if (wrofm_a)   sb_pop_a("ofm_a", enc(4'd3, 12'd0, {6'b0, ofm_a}));
      if (done_a) begin
        done_cnt_a++;
        sb_pop_a("done_a", enc(4'd4, 12'd0, {6'b0, ofm_a}));
      end
      if (winrst_a) winrst_cnt_a++;
      if (remac_a) begin
        check("maccount_a", 32'(mc_a), 32'(exp_mc_a));
        exp_mc_a = (exp_mc_a == 15) ? 0 : exp_mc_a + 1;
      end
    end
  end

  // Instance B: full default run, independent address/count model.
  always @(negedge clk) begin
    if (!rst && busy_b) begin
      check("onehot_b", 32'($countones({wenbuff_b, wewin_b, remac_b, adden_b,
                                         wrofm_b, winrst_b, |wef_b}) > 1), 32'd0);
      check("rdonly_b", 32'(wrmem_b), 32'd0);
      if (|wef_b) begin
        check("filt_b", {12'd0, wef_b, fc_b, mem_b},
              {12'd0, 4'(1 << (filt_b / 16)), 6'(filt_b % 16), 10'(filt_b)});
        filt_b++;
      end
      if (wenbuff_b) begin
        check("buf_b", {16'd0, ba_b, mem_b}, {16'd0, 6'(buf_b), 10'(64 + win_b + buf_b)});
        buf_b = (buf_b == 3) ? 0 : buf_b + 1;
      end
      if (remac_b) begin
        check("maccount_b", 32'(mc_b), 32'(mac_cnt_b % 16));
        mac_cnt_b++;
      end
      if (wrofm_b) check("ofm_b", 32'(ofm_b), 32'(win_b));
      if (winrst_b) win_b++;
    end
  end

  // Instance C: filter addresses wrapping past 1023.
  always @(negedge clk) begin
    if (!rst) begin
      check("rdonly_c", 32'(wrmem_c), 32'd0);
      if (|wef_c) begin
        if (q_c.size() == 0) check("filt_c_unexpected", {15'd0, wef_c, fc_c, mem_c}, 32'hDEAD_BEEF);
        else check("filt_c", enc(4'd1, {5'b0, wef_c, fc_c}, {6'b0, mem_c}), q_c.pop_front());
      end
    end
  end

  function automatic logic sig(input int which);
    case (which)
      0:       return done_a;
      1:       return done_b;
      2:       return done_c;
      3:       return remac_a && (mc_a == 6'd7);
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int which, input string tag, input int budget, output int n);
    n = 0;
    while (!sig(which) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!sig(which)) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic pulse(input int which);
    case (which)
      0: start_a = 1'b1;
      1: start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    winrst_cnt_a = 0;
    done_cnt_a = 0;
    exp_mc_a = 0;
    mac_cnt_b = 0;
    filt_b = 0;
    win_b = 0;
    buf_b = 0;
    repeat (3) @(negedge clk);
    check("rst_strobes", {19'd0, busy_a, done_a, wenbuff_a, wrmem_a, wewin_a, remac_a,
                          adden_a, winrst_a, wrofm_a, wef_a}, 32'd0);
    check("rst_counts", {14'd0, fc_a, mc_a, ba_a}, 32'd0);
    check("rst_addrs", {12'd0, mem_a, ofm_a}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_no_start", 32'(busy_a), 32'd0);

    // Two-window run: latency, addresses, single window reset.
    push_run_a();
    pulse(0);
    check("busy_rise", 32'(busy_a), 32'd1);
    wait_for(0, "run1", 400, n);
    check("done_latency", 32'(n), 32'd141);
    @(negedge clk);
    check("done_one_cycle", {30'd0, done_a, busy_a}, 32'd0);
    check("winrst_once", 32'(winrst_cnt_a), 32'd1);
    check("sb_empty_1", 32'(q_a.size()), 32'd0);

    // start pulses while busy are ignored.
    done_cnt_a = 0;
    push_run_a();
    pulse(0);
    for (int i = 0; i < 10; i++) begin
      repeat (9) @(negedge clk);
      pulse(0);
    end
    wait_for(0, "run2", 400, n);
    repeat (20) @(negedge clk);
    check("single_done", 32'(done_cnt_a), 32'd1);
    check("no_restart", 32'(busy_a), 32'd0);
    check("sb_empty_2", 32'(q_a.size()), 32'd0);

    // start held through DONE relaunches only after one IDLE cycle.
    done_cnt_a = 0;
    push_run_a();
    push_run_a();
    start_a = 1'b1;
    @(negedge clk);
    wait_for(0, "run3", 400, n);
    @(negedge clk);
    check("held_idle", 32'(busy_a), 32'd0);
    @(negedge clk);
    check("held_restart", 32'(busy_a), 32'd1);
    start_a = 1'b0;
    wait_for(0, "run4", 400, n);
    @(negedge clk);
    check("held_two_done", 32'(done_cnt_a), 32'd2);
    check("sb_empty_3", 32'(q_a.size()), 32'd0);

    // Asynchronous reset in the middle of MAC.
    done_cnt_a = 0;
    push_run_a();
    pulse(0);
    wait_for(3, "mac7", 400, n);
    #1 rst = 1'b1;
    #1;
    check("arst_strobes", {19'd0, busy_a, done_a, wenbuff_a, wrmem_a, wewin_a, remac_a,
                           adden_a, winrst_a, wrofm_a, wef_a}, 32'd0);
    check("arst_counts", {14'd0, fc_a, mc_a, ba_a}, 32'd0);
    check("arst_addrs", {12'd0, mem_a, ofm_a}, 32'd0);
    q_a.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("arst_no_done", 32'(done_cnt_a), 32'd0);
    check("arst_stays_idle", 32'(busy_a), 32'd0);

    // Full default run on instance B.
    pulse(1);
    wait_for(1, "runb", 3000, n);
    check("full_latency", 32'(n), 32'd2559);
    check("mac_total", 32'(mac_cnt_b), 32'd1024);
    check("filt_total", 32'(filt_b), 32'd64);
    check("win_total", 32'(win_b), 32'd63);

    // Filter address wrap on instance C.
    for (int fc = 0; fc < 8; fc++)
      q_c.push_back(enc(4'd1, {5'b0, 1'b1, 6'(fc)}, 16'((1020 + fc) % 1024)));
    pulse(2);
    wait_for(2, "runc", 200, n);
    check("wrap_latency", 32'(n), 32'd30);
    @(negedge clk);
    check("wrap_sb_empty", 32'(q_c.size()), 32'd0);
    check("wrap_idle", {busy_c, done_c, wenbuff_c, wewin_c, remac_c, adden_c, winrst_c,
                        wrofm_c, 2'b0, ba_c, mc_c, ofm_c}, 32'd0);
    check("wrap_idle_addr", {16'd0, fc_c, mem_c}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
